// File: rtl/matrix_serializer.sv
// Serializes result-matrix rows into byte frames:
// 0xA5 header, length, MSB-first element bytes, then an XOR checksum.
module matrix_serializer #(
   parameter int RESULT_WIDTH = 16,
   parameter int MAX_ROW_SIZE = 32,
   parameter int LEN_W        = $clog2(MAX_ROW_SIZE+1)
) (
   input  logic                                 eth_refclk,
   input  logic                                 rst_n,
   input  logic                                 row_valid,
   output logic                                 row_ready,
   input  logic [MAX_ROW_SIZE*RESULT_WIDTH-1:0] row_data,
   input  logic [LEN_W-1:0]                     row_len,
   input  logic                                 last_row,
   output logic [7:0]                           tx_data,
   output logic                                 tx_valid,
   input  logic                                 tx_ready,
   output logic                                 tx_last,
   output logic                                 complete
);

   localparam int BPE    = RESULT_WIDTH / 8;
   localparam int KW     = (BPE > 1) ? $clog2(BPE) : 1;
   localparam int BCNT_W = $clog2(MAX_ROW_SIZE*BPE + 1);
   localparam int DW     = MAX_ROW_SIZE * RESULT_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LEN,
      DATA,
      CSUM
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_armed;
   logic [DW-1:0]       r_data;
   logic [LEN_W-1:0]    r_len;
   logic                r_last;
   logic [LEN_W-1:0]    r_ecnt;
   logic [KW-1:0]       r_kcnt;
   logic [7:0]          r_csum;
   logic                r_complete;

   logic                w_accept;
   logic                w_beat;
   logic [LEN_W-1:0]    w_eff_len;
   logic [7:0]          w_lenb;
   logic                w_last_k;
   logic                w_last_e;
   logic [BCNT_W-1:0]   w_bidx;
   logic [7:0]          w_elem_byte;

   assign w_accept  = row_valid && r_armed && (r_state == IDLE);
   assign w_beat    = tx_ready && (r_state != IDLE);
   assign w_eff_len = (row_len > LEN_W'(MAX_ROW_SIZE)) ?
                      LEN_W'(MAX_ROW_SIZE) : row_len;
   assign w_lenb    = 8'(r_len);
   assign w_last_k  = (r_kcnt == KW'(BPE-1));
   assign w_last_e  = (r_ecnt == r_len - LEN_W'(1));

   // Byte index into the row: element-major, MSB byte of each element first.
   assign w_bidx = BCNT_W'(r_ecnt) * BCNT_W'(BPE)
                 + BCNT_W'(BPE-1) - BCNT_W'(r_kcnt);
   assign w_elem_byte = r_data[{w_bidx, 3'b000} +: 8];

   assign complete = r_complete;

   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      row_ready = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      tx_last   = 1'b0;
      unique case (r_state)
         IDLE: begin
            row_ready = r_armed;
            if (w_accept) w_next = HDR;
         end
         HDR: begin
            tx_valid = 1'b1;
            tx_data  = 8'hA5;
            if (w_beat) w_next = LEN;
         end
         LEN: begin
            tx_valid = 1'b1;
            tx_data  = w_lenb;
            if (w_beat) w_next = (r_len == '0) ? CSUM : DATA;
         end
         DATA: begin
            tx_valid = 1'b1;
            tx_data  = w_elem_byte;
            if (w_beat && w_last_k && w_last_e) w_next = CSUM;
         end
         CSUM: begin
            tx_valid = 1'b1;
            tx_data  = r_csum;
            tx_last  = 1'b1;
            if (w_beat) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // r_armed holds row_ready low until the first edge after reset release.
   always_ff @(posedge eth_refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed    <= 1'b0;
         r_data     <= '0;
         r_len      <= '0;
         r_last     <= 1'b0;
         r_ecnt     <= '0;
         r_kcnt     <= '0;
         r_csum     <= 8'h00;
         r_complete <= 1'b0;
      end else begin
         r_armed    <= 1'b1;
         r_complete <= (r_state == CSUM) && w_beat && r_last;
         if (w_accept) begin
            r_data <= row_data;
            r_len  <= w_eff_len;
            r_last <= last_row;
            r_ecnt <= '0;
            r_kcnt <= '0;
            r_csum <= 8'h00;
         end else if (w_beat) begin
            case (r_state)
               LEN:  r_csum <= w_lenb;
               DATA: begin
                  r_csum <= r_csum ^ w_elem_byte;
                  if (w_last_k) begin
                     r_kcnt <= '0;
                     r_ecnt <= r_ecnt + 1'b1;
                  end else begin
                     r_kcnt <= r_kcnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
